ps2_direction_decoder: RTL and testbench

- Consumes the byte stream from the PS/2 keyboard controller (`ps2_key_data` plus the `ps2_key_pressed` strobe).
- Decodes Set-2 make/break sequences, including the E0 and F0 prefixes, into Pacman movement and control commands.
- Outputs a latched requested direction, a held-key mask, and single-cycle event pulses for the game FSM.
- Sits directly downstream of the keyboard controller in the top level.

---
 rtl/ps2_direction_decoder.sv | 160 ++++++++++++++++
 tb/tb_ps2_direction_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_direction_decoder.sv
// Set-2 scancode decoder (E0/F0 prefixes) for Pacman direction, start and pause control.
// Outputs are registered one cycle after the final byte's strobe; no backpressure, every strobe is consumed.
module ps2_direction_decoder #(
    parameter int TIMEOUT_CYCLES = 250000,
    parameter int CNT_W          = 18
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] key_data,
    input  logic       key_strobe,
    output logic [1:0] dir,
    output logic       dir_valid,
    output logic       dir_change,
    output logic [3:0] held,
    output logic       start_pulse,
    output logic       paused,
    output logic       prefix_drop
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dir_q, dir_d;
    logic             dir_valid_q, dir_valid_d;
    logic             dir_change_q, dir_change_d;
    logic [3:0]       held_q, held_d;
    logic             start_pulse_q, start_pulse_d;
    logic             paused_q, paused_d;
    logic             prefix_drop_q, prefix_drop_d;

    logic       is_e0, is_f0, extended, breaking;
    logic       key_is_dir, key_is_enter, key_is_esc;
    logic [1:0] key_dir;

    assign is_e0    = (key_data == 8'hE0);
    assign is_f0    = (key_data == 8'hF0);
    assign extended = (state_q == EXT) || (state_q == EXT_BRK);
    assign breaking = (state_q == BRK) || (state_q == EXT_BRK);

    // Arrow keys and WASD map onto the same direction codes so they share held bits.
    always_comb begin
        key_is_dir   = 1'b0;
        key_is_enter = 1'b0;
        key_is_esc   = 1'b0;
        key_dir      = 2'd0;
        if (extended) begin
            case (key_data)
                8'h75:   begin key_is_dir = 1'b1; key_dir = 2'd0; end
                8'h72:   begin key_is_dir = 1'b1; key_dir = 2'd1; end
                8'h6B:   begin key_is_dir = 1'b1; key_dir = 2'd2; end
                8'h74:   begin key_is_dir = 1'b1; key_dir = 2'd3; end
                default: ;
            endcase
        end else begin
            case (key_data)
                8'h1D:   begin key_is_dir = 1'b1; key_dir = 2'd0; end
                8'h1B:   begin key_is_dir = 1'b1; key_dir = 2'd1; end
                8'h1C:   begin key_is_dir = 1'b1; key_dir = 2'd2; end
                8'h23:   begin key_is_dir = 1'b1; key_dir = 2'd3; end
                8'h5A:   key_is_enter = 1'b1;
                8'h76:   key_is_esc   = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dir_d         = dir_q;
        dir_valid_d   = dir_valid_q;
        held_d        = held_q;
        paused_d      = paused_q;
        dir_change_d  = 1'b0;
        start_pulse_d = 1'b0;
        prefix_drop_d = 1'b0;

        if (key_strobe) begin
            // Any byte, prefix or not, restarts the prefix timer.
            cnt_d = '0;
            case (state_q)
                IDLE:    state_d = is_e0 ? EXT : (is_f0 ? BRK : IDLE);
                EXT:     state_d = is_f0 ? EXT_BRK : (is_e0 ? EXT : IDLE);
                BRK:     state_d = is_e0 ? EXT : (is_f0 ? BRK : IDLE);
                EXT_BRK: state_d = (is_e0 || is_f0) ? EXT_BRK : IDLE;
                default: state_d = IDLE;
            endcase

            if (!is_e0 && !is_f0) begin
                if (key_is_dir) begin
                    if (breaking) begin
                        held_d[key_dir] = 1'b0;
                    end else begin
                        held_d[key_dir] = 1'b1;
                        if (!dir_valid_q || (dir_q != key_dir)) begin
                            dir_d        = key_dir;
                            dir_valid_d  = 1'b1;
                            dir_change_d = 1'b1;
                        end
                    end
                end
                if (!breaking && key_is_enter) begin
                    start_pulse_d = 1'b1;
                end
                if (!breaking && key_is_esc) begin
                    paused_d = ~paused_q;
                end
            end
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d       = IDLE;
                cnt_d         = '0;
                prefix_drop_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dir_q         <= 2'd0;
            dir_valid_q   <= 1'b0;
            dir_change_q  <= 1'b0;
            held_q        <= 4'd0;
            start_pulse_q <= 1'b0;
            paused_q      <= 1'b0;
            prefix_drop_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            dir_valid_q   <= dir_valid_d;
            dir_change_q  <= dir_change_d;
            held_q        <= held_d;
            start_pulse_q <= start_pulse_d;
            paused_q      <= paused_d;
            prefix_drop_q <= prefix_drop_d;
        end
    end

    assign dir         = dir_q;
    assign dir_valid   = dir_valid_q;
    assign dir_change  = dir_change_q;
    assign held        = held_q;
    assign start_pulse = start_pulse_q;
    assign paused      = paused_q;
    assign prefix_drop = prefix_drop_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Bench for ps2_direction_decoder: directed scenarios plus random byte streams against a timestamp/flag model.
module tb_ps2_direction_decoder;

    localparam int T = 16;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       key_strobe = 1'b0;
    logic [1:0] dir;
    logic       dir_valid, dir_change, start_pulse, paused, prefix_drop;
    logic [3:0] held;

    ps2_direction_decoder #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .key_data   (key_data),
        .key_strobe (key_strobe),
        .dir        (dir),
        .dir_valid  (dir_valid),
        .dir_change (dir_change),
        .held       (held),
        .start_pulse(start_pulse),
        .paused     (paused),
        .prefix_drop(prefix_drop)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: pending prefix flags plus the cycle stamp of the last prefix byte.
    bit         m_ext, m_brk;
    longint     cyc, last_pref;
    logic [1:0] m_dir;
    logic       m_valid, m_chg, m_start, m_paused, m_drop;
    logic [3:0] m_held;

    logic [7:0] ext_codes   [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] plain_codes [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};

    function automatic int dir_of(bit ext, logic [7:0] b);
        for (int i = 0; i < 4; i++) begin
            if (ext && b == ext_codes[i]) return i;
            if (!ext && b == plain_codes[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_ext = 0; m_brk = 0; cyc = 0; last_pref = 0;
            m_dir = 0; m_valid = 0; m_chg = 0; m_start = 0;
            m_paused = 0; m_drop = 0; m_held = 0;
        end else begin
            int d;
            cyc++;
            m_chg = 0; m_start = 0; m_drop = 0;
            if (key_strobe) begin
                if (key_data == 8'hE0) begin
                    m_brk = m_ext && m_brk;
                    m_ext = 1;
                    last_pref = cyc;
                end else if (key_data == 8'hF0) begin
                    m_brk = 1;
                    last_pref = cyc;
                end else begin
                    d = dir_of(m_ext, key_data);
                    if (d >= 0) begin
                        if (m_brk) m_held[d] = 1'b0;
                        else begin
                            m_held[d] = 1'b1;
                            if (!m_valid || m_dir != d[1:0]) begin
                                m_dir = d[1:0]; m_valid = 1; m_chg = 1;
                            end
                        end
                    end else if (!m_ext && !m_brk) begin
                        if (key_data == 8'h5A) m_start = 1;
                        if (key_data == 8'h76) m_paused = ~m_paused;
                    end
                    m_ext = 0; m_brk = 0;
                end
            end else if ((m_ext || m_brk) && (cyc - last_pref == T)) begin
                m_ext = 0; m_brk = 0; m_drop = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            n_vec++;
            if ({dir, dir_valid, dir_change, held, start_pulse, paused, prefix_drop} !==
                {m_dir, m_valid, m_chg, m_held, m_start, m_paused, m_drop}) begin
                n_bad++;
                $display("FAIL outputs t=%0t: dut dir=%0d vld=%0d chg=%0d held=%b start=%0d paused=%0d drop=%0d, model dir=%0d vld=%0d chg=%0d held=%b start=%0d paused=%0d drop=%0d",
                         $time, dir, dir_valid, dir_change, held, start_pulse, paused, prefix_drop,
                         m_dir, m_valid, m_chg, m_held, m_start, m_paused, m_drop);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        key_strobe = 1'b1;
        key_data   = b;
        @(posedge clock);
        #1;
        key_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int gap;
        logic [7:0] b;
        logic [7:0] pool [13] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                                  8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h5A, 8'h76, 8'h00};

        idle(3);
        resetn = 1'b1;
        chk_en = 1'b1;
        idle(1);
        check("reset_dir", dir, 0);
        check("reset_dir_valid", dir_valid, 0);
        check("reset_held", held, 0);
        check("reset_paused", paused, 0);

        send(8'hE0); send(8'h6B);
        check("left_dir_change", dir_change, 1);
        check("left_dir", dir, 2);
        check("left_dir_valid", dir_valid, 1);
        check("left_held", held, 4'b0100);
        idle(1);
        check("left_change_one_cycle", dir_change, 0);

        repeat (3) begin
            send(8'hE0); send(8'h6B);
            check("typematic_no_change", dir_change, 0);
        end
        send(8'hE0); send(8'hF0); send(8'h6B);
        check("left_break_held", held, 0);
        check("left_break_dir", dir, 2);

        send(8'hE0); send(8'h6B);
        send(8'h1D);
        check("w_over_left_dir", dir, 0);
        check("w_over_left_held", held, 4'b0101);
        check("w_over_left_change", dir_change, 1);
        send(8'hF0); send(8'h1C);
        check("a_break_clears_left", held, 4'b0001);
        check("a_break_dir", dir, 0);

        send(8'hE0); send(8'h74);
        send(8'hE0); send(8'hF0); send(8'h74);
        check("right_dir", dir, 3);

        send(8'hE0);
        idle(T - 1);
        check("no_drop_before_expiry", prefix_drop, 0);
        idle(1);
        check("prefix_drop_pulse", prefix_drop, 1);
        idle(1);
        check("prefix_drop_one_cycle", prefix_drop, 0);
        send(8'h75);
        check("plain_75_ignored_dir", dir, 3);
        check("plain_75_ignored_held", held, 4'b0001);

        send(8'hE0);
        idle(T - 1);
        send(8'h75);
        check("strobe_wins_dir", dir, 0);
        check("strobe_wins_change", dir_change, 1);
        check("strobe_wins_no_drop", prefix_drop, 0);
        idle(1);
        check("strobe_wins_no_late_drop", prefix_drop, 0);

        send(8'h5A);
        check("enter_start", start_pulse, 1);
        idle(1);
        check("enter_start_one_cycle", start_pulse, 0);
        send(8'h76);
        check("esc_pause_on", paused, 1);
        send(8'h76);
        check("esc_pause_off", paused, 0);
        send(8'hF0); send(8'h76);
        check("esc_break_ignored", paused, 0);

        for (int i = 0; i < 400; i++) begin
            b = pool[$urandom_range(0, 12)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            send(b);
            if ($urandom_range(0, 9) < 8) gap = $urandom_range(0, 2);
            else gap = $urandom_range(T - 2, T + 1);
            idle(gap);
        end

        send(8'hE0); send(8'hF0);
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        idle(1);
        send(8'h74);
        check("post_reset_dir", dir, 0);
        check("post_reset_dir_valid", dir_valid, 0);
        check("post_reset_held", held, 0);
        check("post_reset_paused", paused, 0);
        check("post_reset_change", dir_change, 0);
        idle(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
